// File: rtl/instr_encoder_loader_if.sv
// Host-facing instruction channel and program-memory write port of instr_encoder_loader.
// Instruction channel: a transfer happens on a rising clk edge where in_valid and in_ready are both 1; fields are sampled only then. Memory port: mem_req/mem_addr/mem_wdata stay stable until a cycle with mem_gnt=1 completes the write.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [2:0]        in_rx;
  logic [2:0]        in_ry;
  logic [15:0]       in_imm;
  logic              in_last;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_gnt;

  modport master (
    output in_valid, in_op, in_rx, in_ry, in_imm, in_last, mem_gnt,
    input  in_ready, mem_req, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rx, in_ry, in_imm, in_last, mem_gnt,
    output in_ready, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instructions into 16-bit CPU words and writes them sequentially into
// program memory; li16 expands into mvi + mvhi and is range-checked before any write.
module instr_encoder_loader #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_W-1:0] LIMIT_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  start_addr_sel,
  input  logic [ADDR_W-1:0]     start_addr,
  instr_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_W-1:0]     word_count,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_ENC    = 3'd2,
    S_WRITE1 = 3'd3,
    S_WRITE2 = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] WC_ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] EVEN_MASK  = ~ADDR_W'(1);
  localparam logic [ADDR_W:0]   STEP_WIDE  = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0]   LIMIT_WIDE = {1'b0, LIMIT_ADDR};

  localparam logic [4:0] OP_MVI  = 5'b10000;
  localparam logic [4:0] OP_MVHI = 5'b10110;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wc_q, wc_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [4:0]        op_q, op_d;
  logic [2:0]        rx_q, rx_d;
  logic [2:0]        ry_q, ry_d;
  logic [15:0]       imm_q, imm_d;
  logic              last_q, last_d;

  logic [15:0]       word1, word2;
  logic [1:0]        enc_err;
  logic              is_li16;
  logic [ADDR_W:0]   addr_plus2;

  // Encoder works on the captured fields, which stay put through both write states.
  always_comb begin
    word1      = '0;
    word2      = '0;
    enc_err    = 2'd0;
    is_li16    = 1'b0;
    addr_plus2 = {1'b0, addr_q} + STEP_WIDE;
    word1[4:0] = op_q;
    case (op_q)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101: begin
        word1[7:5]  = rx_q;
        word1[10:8] = ry_q;
      end
      5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110: begin
        word1[7:5]  = rx_q;
        word1[15:8] = imm_q[7:0];
      end
      5'b01000, 5'b01001, 5'b01010: begin
        word1[7:5] = rx_q;
      end
      5'b11000, 5'b11001, 5'b11010: begin
        word1[15:5] = imm_q[10:0];
        if (imm_q[15:11] != {5{imm_q[10]}}) enc_err = 2'd3;
      end
      5'b11111: begin
        is_li16 = 1'b1;
        word1   = {imm_q[7:0], rx_q, OP_MVI};
        word2   = {imm_q[15:8], rx_q, OP_MVHI};
      end
      default: enc_err = 2'd1;
    endcase
    // Both words of li16 must fit before the first is written.
    if (enc_err == 2'd0) begin
      if ((addr_q > LIMIT_ADDR) || (is_li16 && (addr_plus2 > LIMIT_WIDE))) enc_err = 2'd2;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wc_d       = wc_q;
    err_code_d = err_code_q;
    op_d       = op_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    imm_d      = imm_q;
    last_d     = last_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          addr_d     = start_addr_sel ? (start_addr & EVEN_MASK) : BASE_ADDR;
          wc_d       = '0;
          err_code_d = 2'd0;
          state_d    = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (bus.in_valid) begin
          op_d    = bus.in_op;
          rx_d    = bus.in_rx;
          ry_d    = bus.in_ry;
          imm_d   = bus.in_imm;
          last_d  = bus.in_last;
          state_d = S_ENC;
        end
      end
      S_ENC: begin
        if (enc_err != 2'd0) begin
          err_code_d = enc_err;
          state_d    = S_ERR;
        end else begin
          state_d = S_WRITE1;
        end
      end
      S_WRITE1: begin
        if (bus.mem_gnt) begin
          addr_d = addr_q + ADDR_STEP;
          wc_d   = wc_q + WC_ONE;
          if (is_li16)     state_d = S_WRITE2;
          else if (last_q) state_d = S_DONE;
          else             state_d = S_ACCEPT;
        end
      end
      S_WRITE2: begin
        if (bus.mem_gnt) begin
          addr_d  = addr_q + ADDR_STEP;
          wc_d    = wc_q + WC_ONE;
          state_d = last_q ? S_DONE : S_ACCEPT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= BASE_ADDR;
      wc_q       <= '0;
      err_code_q <= 2'd0;
      op_q       <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      imm_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wc_q       <= wc_d;
      err_code_q <= err_code_d;
      op_q       <= op_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      imm_q      <= imm_d;
      last_q     <= last_d;
    end
  end

  // Address and data are gated by the request so every output reads 0 outside a write.
  assign bus.in_ready  = (state_q == S_ACCEPT);
  assign bus.mem_req   = (state_q == S_WRITE1) || (state_q == S_WRITE2);
  assign bus.mem_addr  = bus.mem_req ? addr_q : '0;
  assign bus.mem_wdata = (state_q == S_WRITE1) ? word1 :
                         (state_q == S_WRITE2) ? word2 : 16'h0000;
  assign busy          = (state_q == S_ACCEPT) || (state_q == S_ENC) ||
                         (state_q == S_WRITE1) || (state_q == S_WRITE2);
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERR);
  assign err_code      = err_code_q;
  assign word_count    = wc_q;
  assign dbg_state     = state_q;

endmodule
